// File: rtl/bikelight_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bikelight_pkg
//  Purpose  : Shared mode encodings and mode sequencing helper for the
//             bike light controller.
//  Revision : 1.0 - initial release
// ============================================================================
package bikelight_pkg;

    // Light modes; encodings are visible on the mode output port
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_DIM   = 2'b11
    } mode_t;

    // Short-press sequence: OFF -> ON -> BLINK -> DIM -> OFF
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:   return MODE_ON;
            MODE_ON:    return MODE_BLINK;
            MODE_BLINK: return MODE_DIM;
            MODE_DIM:   return MODE_OFF;
            default:    return MODE_OFF;
        endcase
    endfunction

endpackage : bikelight_pkg
`default_nettype wire

// File: rtl/bikelight_controller_modcounter.sv
`default_nettype none
// ============================================================================
//  Module   : modcounter
//  Purpose  : Modulo-N counter (0..N-1) with enable, synchronous restart and
//             a wrap pulse on the terminal count.
//  Revision : 1.0 - initial release
// ============================================================================
module modcounter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Terminal count only counts as a wrap while the counter is advancing
    assign wrap  = en && (count_q == W'(N - 1));
    assign count = count_q;

    // Next count: restart has priority, otherwise advance and wrap at N-1
    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : modcounter
`default_nettype wire

// File: rtl/bikelight_controller.sv
`default_nettype none
// ============================================================================
//  Module   : bikelight_controller
//  Purpose  : Bike light mode controller. Short presses step the mode
//             OFF -> ON -> BLINK -> DIM -> OFF, a long hold forces OFF, and
//             the LED drive is decoded from registered state only.
//  Revision : 1.0 - initial release
// ============================================================================
module bikelight_controller
    import bikelight_pkg::*;
#(
    parameter int BLINK_HALF = 5000,
    parameter int DIM_PERIOD = 4,
    parameter int DIM_ON     = 1,
    parameter int LONG_PRESS = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_rise,
    input  logic       btn_level,
    output logic       led,
    output logic [1:0] mode
);

    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int DIM_W   = (DIM_PERIOD > 1) ? $clog2(DIM_PERIOD) : 1;
    localparam int HOLD_W  = (LONG_PRESS > 1) ? $clog2(LONG_PRESS) : 1;

    // Reject parameter sets the counters cannot represent
    if (BLINK_HALF < 1) begin : g_bad_blink_half
        $error("bikelight_controller: BLINK_HALF must be >= 1");
    end
    if (DIM_PERIOD < 1) begin : g_bad_dim_period
        $error("bikelight_controller: DIM_PERIOD must be >= 1");
    end
    if (DIM_ON < 0 || DIM_ON > DIM_PERIOD) begin : g_bad_dim_on
        $error("bikelight_controller: DIM_ON must be in 0..DIM_PERIOD");
    end
    if (LONG_PRESS < 2) begin : g_bad_long_press
        $error("bikelight_controller: LONG_PRESS must be >= 2");
    end

    mode_t              mode_q;
    mode_t              mode_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [HOLD_W-1:0]  hold_cnt_d;
    logic               long_fired_q;
    logic               long_fired_d;
    logic               blink_phase_q;
    logic               blink_phase_d;
    logic               force_off;

    logic               blink_run;
    logic               blink_wrap;
    logic [BLINK_W-1:0] blink_cnt;
    logic               dim_run;
    logic               dim_wrap;
    logic [DIM_W-1:0]   dim_cnt;

    // Hold tracking and mode sequencing; force-OFF overrides any short press
    always_comb begin
        hold_cnt_d   = '0;
        long_fired_d = 1'b0;
        force_off    = btn_level && (hold_cnt_q == HOLD_W'(LONG_PRESS - 1))
                       && !long_fired_q;
        if (btn_level) begin
            hold_cnt_d   = (hold_cnt_q == HOLD_W'(LONG_PRESS - 1)) ?
                           hold_cnt_q : hold_cnt_q + HOLD_W'(1);
            long_fired_d = long_fired_q || force_off;
        end

        mode_d = mode_q;
        if (force_off) begin
            mode_d = MODE_OFF;
        end else if (btn_rise && !long_fired_q) begin
            mode_d = next_mode(mode_q);
        end
    end

    // Counters run only while staying in their mode; entering or leaving clears them
    assign blink_run = (mode_q == MODE_BLINK) && (mode_d == MODE_BLINK);
    assign dim_run   = (mode_q == MODE_DIM)   && (mode_d == MODE_DIM);

    // Blink phase starts high on entry, toggles at each half-period wrap
    always_comb begin
        blink_phase_d = 1'b0;
        if (mode_d == MODE_BLINK) begin
            if (mode_q != MODE_BLINK) begin
                blink_phase_d = 1'b1;
            end else begin
                blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q        <= MODE_OFF;
            hold_cnt_q    <= '0;
            long_fired_q  <= 1'b0;
            blink_phase_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            hold_cnt_q    <= hold_cnt_d;
            long_fired_q  <= long_fired_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    modcounter #(
        .N (BLINK_HALF),
        .W (BLINK_W)
    ) u_blink_cnt (
        .clk     (clk),
        .reset   (reset),
        .restart (!blink_run),
        .en      (blink_run),
        .count   (blink_cnt),
        .wrap    (blink_wrap)
    );

    modcounter #(
        .N (DIM_PERIOD),
        .W (DIM_W)
    ) u_dim_cnt (
        .clk     (clk),
        .reset   (reset),
        .restart (!dim_run),
        .en      (dim_run),
        .count   (dim_cnt),
        .wrap    (dim_wrap)
    );

    // LED decode from registered state only, so no input can glitch the pin
    always_comb begin
        led = 1'b0;
        case (mode_q)
            MODE_OFF:   led = 1'b0;
            MODE_ON:    led = 1'b1;
            MODE_BLINK: led = blink_phase_q;
            MODE_DIM:   led = (32'(dim_cnt) < DIM_ON);
            default:    led = 1'b0;
        endcase
    end

    assign mode = mode_q;

endmodule : bikelight_controller
`default_nettype wire

// File: tb/tb_bikelight_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bikelight_controller
//  Purpose  : Directed self-checking bench for bikelight_controller. A second
//             instance with DIM_ON=DIM_PERIOD shares the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bikelight_controller;

    localparam logic [1:0] OFF   = 2'b00;
    localparam logic [1:0] ON    = 2'b01;
    localparam logic [1:0] BLINK = 2'b10;
    localparam logic [1:0] DIM   = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_rise;
    logic       btn_level;
    logic       led;
    logic [1:0] mode;
    logic       led2;
    logic [1:0] mode2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [1:0] mode;
        logic       led;
        bit         chk2;
        logic       led2;
    } exp_t;

    exp_t sb[$];

    bikelight_controller #(
        .BLINK_HALF (4),
        .DIM_PERIOD (4),
        .DIM_ON     (1),
        .LONG_PRESS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_rise  (btn_rise),
        .btn_level (btn_level),
        .led       (led),
        .mode      (mode)
    );

    bikelight_controller #(
        .BLINK_HALF (4),
        .DIM_PERIOD (4),
        .DIM_ON     (4),
        .LONG_PRESS (8)
    ) dut_full (
        .clk       (clk),
        .reset     (reset),
        .btn_rise  (btn_rise),
        .btn_level (btn_level),
        .led       (led2),
        .mode      (mode2)
    );

    always #5 clk = ~clk;

    // Pop every pending expectation and compare against the outputs
    task automatic check_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (mode === e.mode) else begin
                errors++;
                $error("FAIL %s mode got=%b exp=%b", e.tag, mode, e.mode);
            end
            checks++;
            assert (led === e.led) else begin
                errors++;
                $error("FAIL %s led got=%b exp=%b", e.tag, led, e.led);
            end
            if (e.chk2) begin
                checks++;
                assert (led2 === e.led2) else begin
                    errors++;
                    $error("FAIL %s led_full got=%b exp=%b", e.tag, led2, e.led2);
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, queue what must appear after the edge, check
    task automatic step(input logic r, input logic l, input logic rs, input string tag,
                        input logic [1:0] m, input logic ld,
                        input bit c2 = 1'b0, input logic ld2 = 1'b0);
        btn_rise  = r;
        btn_level = l;
        reset     = rs;
        sb.push_back('{tag, m, ld, c2, ld2});
        @(negedge clk);
        check_all();
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset dominates active button inputs
        for (int i = 0; i < 3; i++) step(1, 1, 1, "reset_hold", OFF, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, "post_reset", OFF, 0);

        // Short-press cycling with blink and dim waveforms
        step(1, 0, 0, "to_on", ON, 1);
        for (int i = 0; i < 19; i++) step(0, 0, 0, "on_idle", ON, 1);
        step(1, 0, 0, "blink_0", BLINK, 1);
        for (int k = 1; k < 24; k++)
            step(0, 0, 0, $sformatf("blink_%0d", k), BLINK, ((k / 4) % 2) == 0);
        step(1, 0, 0, "dim_0", DIM, 1, 1, 1);
        for (int k = 1; k < 20; k++)
            step(0, 0, 0, $sformatf("dim_%0d", k), DIM, (k % 4) == 0, 1, 1);
        step(1, 0, 0, "wrap_off", OFF, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, "off_idle", OFF, 0);

        // Long press from ON: press advances, 8th held edge forces OFF
        step(1, 0, 0, "lp_on", ON, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, "lp_on_idle", ON, 1);
        step(1, 1, 0, "lp_hold_0", BLINK, 1);
        for (int k = 1; k < 7; k++)
            step(0, 1, 0, $sformatf("lp_hold_%0d", k), BLINK, k < 4);
        step(0, 1, 0, "lp_force_off", OFF, 0);
        for (int i = 0; i < 20; i++)
            step(logic'(i == 10), 1, 0, $sformatf("lp_held_%0d", i), OFF, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, "lp_release", OFF, 0);
        step(1, 0, 0, "lp_press_after", ON, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, "lp_on_after", ON, 1);

        // Press arriving on the same edge as force-OFF loses
        for (int k = 0; k < 7; k++)
            step(0, 1, 0, $sformatf("race_hold_%0d", k), ON, 1);
        step(1, 1, 0, "race_force_wins", OFF, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, "race_release", OFF, 0);

        // Reset in the middle of BLINK clears mode and both counters
        step(1, 0, 0, "mid_on", ON, 1);
        step(1, 0, 0, "mid_blink_0", BLINK, 1);
        step(0, 0, 0, "mid_blink_1", BLINK, 1);
        step(0, 0, 0, "mid_blink_2", BLINK, 1);
        check_int("mid_blink_cnt", int'(dut.blink_cnt), 2);
        step(0, 0, 1, "mid_reset", OFF, 0);
        check_int("mid_reset_blink_cnt", int'(dut.blink_cnt), 0);
        check_int("mid_reset_dim_cnt", int'(dut.dim_cnt), 0);
        step(0, 0, 0, "mid_release", OFF, 0);

        // Long press while already OFF stays OFF; the next press still works
        for (int i = 0; i < 10; i++) step(0, 1, 0, "off_long", OFF, 0);
        step(0, 0, 0, "off_long_release", OFF, 0);
        step(1, 0, 0, "off_long_press", ON, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bikelight_controller
`default_nettype wire
